alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, handshaked successor to the team's combinational ALU.
- Width is parametrised (8/16/32). Adds a persistent flag register, carry-chained ADC/SBB, and an iterative shift-add multiplier with low and high halves.
- Sits between the operand/issue logic and the writeback stage. Valid/ready on both sides, one operation in flight.

Parameters:
W, 8, datapath width; legal values 8, 16, 32.
SHW, derived (3/4/5 for W=8/16/32), shift-amount width; not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept an operation
a  input  W  operand A
b  input  W  operand B; b[SHW-1:0] is the shift amount
op  input  4  opcode
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
y  output  W  result
z  output  1  zero flag (registered)
n  output  1  negative flag, y[W-1] (registered)
c  output  1  carry / borrow-not flag (registered)
v  output  1  signed overflow flag (registered)
busy  output  1  high while in MUL state

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, y=0, z/n/c/v=0, busy=0, iteration counter=0.
  - Reset mid-multiply abandons the operation; no result is produced.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on an edge where in_valid && in_ready.
  - Once out_valid=1, y/z/n/c/v hold stable until the edge where out_ready=1.
  - out_valid clears on that edge unless a new result loads on the same edge.
- Opcodes:
  - 0x0 ADD: c=carry out; v=(a[W-1]==b[W-1])&&(y[W-1]!=a[W-1]).
  - 0x1 SUB: computed as a+~b+1; c=carry out (1 = no borrow); v=(a[W-1]!=b[W-1])&&(y[W-1]!=a[W-1]).
  - 0x2 AND, 0x3 OR, 0x4 XOR, 0x5 NOT a.
  - 0x6 SLL, 0x7 SRL, 0x8 SRA, each shifting by b[SHW-1:0].
  - 0x9 SLT: signed compare; y=1 or 0.
  - 0xA PASS a, 0xB PASS b.
  - 0xC MUL: low W bits of unsigned a*b.
  - 0xD MULH: high W bits of unsigned a*b.
  - 0xE ADC: a+b+c_q.
  - 0xF SBB: a+~b+c_q. c_q is the registered c flag; borrow-in = !c_q.
- Flag rules:
  - Logic, shift, SLT and PASS ops force c=0 and v=0.
  - Every op sets z=(y==0) and n=y[W-1].
  - MUL: c=(high half != 0), v=0. MULH: c=0, v=0.
- Flag register:
  - Updates only when a result loads into the output register.
  - ADC/SBB use c_q from the most recently completed op, including one still held unconsumed.
- Latency, single-cycle ops (0x0-0xB, 0xE, 0xF):
  - Accepted at edge k, result registered at edge k.
  - out_valid is high from edge k through the acceptance edge.
- Multiply FSM, states IDLE and MUL:
  - IDLE->MUL on accepting 0xC/0xD: latch a, b, op; accumulator=0 (2W bits); cnt=0; busy=1.
  - MUL: one shift-add step per edge; cnt increments.
  - On the edge where cnt==W-1: final step; load y and flags; out_valid=1; state=IDLE; busy=0.
  - Accepted at edge k, result at edge k+W.
  - in_ready stays 0 throughout MUL.
- Arithmetic width:
  - Sums are computed in W+1 bits.
  - Product is 2W bits with no truncation before half selection.
  - Multiplier is unsigned only.
- Boundaries:
  - Shift amount 0 returns a unchanged.
  - SRA of a negative value fills with 1s.
  - MUL with b=0 or a=0 still takes W cycles.
  - in_valid while busy is ignored (not accepted).
  - Output register full with out_ready=0 stalls issue.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: 0xE/0xF become signed saturating ADD/SUB instead of ADC/SBB.
  - On signed overflow, y=0x7F..F if a is positive, else 0x80..0.
  - v=1 when saturation occurred; c=0; z/n follow the clamped y.
  - c_q is not used.
- Undefined: 0xE/0xF are ADC/SBB as above; no saturation logic is built.

Test Plan:
1. W=8, ADD a=0x7F b=0x01 -> one edge later y=0x80, n=1, v=1, c=0, z=0.
2. ADD 0xFF+0x01 (y=0x00, c=1, z=1), then ADC a=0x00 b=0x00 -> y=0x01, c=0, z=0; repeat with preceding ADD 0x01+0x01 -> ADC y=0x00, z=1.
3. MUL a=0x10 b=0x10 -> busy for 8 edges, in_ready=0, then y=0x00, c=1, z=1; MULH same operands -> y=0x01, c=0; MUL 0xFF*0xFF -> y=0x01, MULH -> 0xFE.
4. Back-pressure: SUB a=0x05 b=0x07 with out_ready=0 for 3 cycles -> y=0xFE, n=1, c=0 held stable, in_ready=0; out_ready=1 -> out_valid drops next edge unless a new op issues on the same edge.
5. Assert rst_n low at cycle 4 of a MUL -> out_valid=0, busy=0, flags 0 immediately; after release, ADD 0x02+0x03 -> y=0x05 normally.
6. ALU_SAT_EN defined: op 0xE a=0x7F b=0x01 -> y=0x7F, v=1; op 0xF a=0x80 b=0x01 -> y=0x80, v=1, n=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with persistent Z/N/C/V flags, carry-chained ADC/SBB and an iterative shift-add multiplier.
// Latency: single-cycle ops register their result on the accepting edge; MUL/MULH produce their result W edges after acceptance.
// Backpressure: one operation in flight; in_ready drops while multiplying or while a result is held with out_ready low.
//
// Ports: clk/rst_n (rising edge, async active-low reset); in_valid/in_ready/a/b/op issue side;
//        out_valid/out_ready/y/z/n/c/v result side (result and flags held until consumed); busy high in MUL state.
// Optional build macro ALU_SAT_EN: opcodes 0xE/0xF become signed saturating ADD/SUB instead of ADC/SBB.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         z,
    output logic         n,
    output logic         c,
    output logic         v,
    output logic         busy
);
    localparam int SHW = $clog2(W);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_PSA  = 4'hA;
    localparam logic [3:0] OP_PSB  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_MULH = 4'hD;
    localparam logic [3:0] OP_ADC  = 4'hE;
    localparam logic [3:0] OP_SBB  = 4'hF;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_out_valid;
    logic [W-1:0]   r_y;
    logic           r_z, r_n, r_c, r_v;

    logic [W-1:0]   r_ma;
    logic [W-1:0]   r_mb;
    logic           r_mop_hi;
    logic [2*W-1:0] r_acc;
    logic [SHW-1:0] r_cnt;

    logic           w_accept, w_is_mul, w_load_alu, w_start_mul, w_mul_done, w_load;
    logic [W-1:0]   w_b_eff;
    logic           w_cin;
    logic [W:0]     w_sum;
    logic           w_ovf;
    logic [SHW-1:0] w_sh;
    logic [W-1:0]   w_res_y;
    logic           w_res_c, w_res_v;
    logic [2*W-1:0] w_acc_nxt;
    logic [W-1:0]   w_mul_y;
    logic           w_mul_c;
    logic [W-1:0]   w_ld_y;
    logic           w_ld_c, w_ld_v;

    // ---------------- handshake ----------------
    assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = (op == OP_MUL) || (op == OP_MULH);
    assign w_load_alu  = w_accept && !w_is_mul;
    assign w_start_mul = w_accept && w_is_mul;
    assign w_mul_done  = (r_state == S_MUL) && (r_cnt == SHW'(W-1));
    // The two load sources are exclusive: acceptance requires IDLE, completion happens in MUL.
    assign w_load      = w_load_alu || w_mul_done;

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign z         = r_z;
    assign n         = r_n;
    assign c         = r_c;
    assign v         = r_v;
    assign busy      = (r_state == S_MUL);

    // ---------------- shared W+1 bit adder ----------------
    // Subtract-type ops feed ~b; carry-in is 1 for plain SUB and the held carry for ADC/SBB.
    always_comb begin
        w_b_eff = b;
        w_cin   = 1'b0;
        case (op)
            OP_SUB: begin w_b_eff = ~b; w_cin = 1'b1; end
`ifdef ALU_SAT_EN
            OP_ADC: begin w_b_eff = b;  w_cin = 1'b0; end
            OP_SBB: begin w_b_eff = ~b; w_cin = 1'b1; end
`else
            OP_ADC: begin w_b_eff = b;  w_cin = r_c;  end
            OP_SBB: begin w_b_eff = ~b; w_cin = r_c;  end
`endif
            default: ;
        endcase
    end

    assign w_sum = {1'b0, a} + {1'b0, w_b_eff} + {{W{1'b0}}, w_cin};
    // Signed overflow: operands (after inversion) agree in sign but the sum does not.
    assign w_ovf = (a[W-1] == w_b_eff[W-1]) && (w_sum[W-1] != a[W-1]);
    assign w_sh  = b[SHW-1:0];

    // ---------------- single-cycle result ----------------
    always_comb begin
        w_res_y = '0;
        w_res_c = 1'b0;
        w_res_v = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                w_res_y = w_sum[W-1:0];
                w_res_c = w_sum[W];
                w_res_v = w_ovf;
            end
`ifdef ALU_SAT_EN
            OP_ADC, OP_SBB: begin
                // Clamp toward the sign of a; carry is meaningless for saturating ops.
                if (w_ovf)
                    w_res_y = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                else
                    w_res_y = w_sum[W-1:0];
                w_res_c = 1'b0;
                w_res_v = w_ovf;
            end
`else
            OP_ADC, OP_SBB: begin
                w_res_y = w_sum[W-1:0];
                w_res_c = w_sum[W];
                w_res_v = w_ovf;
            end
`endif
            OP_AND: w_res_y = a & b;
            OP_OR:  w_res_y = a | b;
            OP_XOR: w_res_y = a ^ b;
            OP_NOT: w_res_y = ~a;
            OP_SLL: w_res_y = a << w_sh;
            OP_SRL: w_res_y = a >> w_sh;
            OP_SRA: w_res_y = $signed(a) >>> w_sh;
            OP_SLT: w_res_y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_PSA: w_res_y = a;
            OP_PSB: w_res_y = b;
            default: ;
        endcase
    end

    // ---------------- shift-add multiplier ----------------
    // Step cnt adds a<<cnt when multiplier bit cnt is set; the final step is folded into the load.
    assign w_acc_nxt = r_acc + (r_mb[r_cnt] ? ({{W{1'b0}}, r_ma} << r_cnt) : {(2*W){1'b0}});
    assign w_mul_y   = r_mop_hi ? w_acc_nxt[2*W-1:W] : w_acc_nxt[W-1:0];
    assign w_mul_c   = !r_mop_hi && (w_acc_nxt[2*W-1:W] != {W{1'b0}});

    assign w_ld_y = w_mul_done ? w_mul_y : w_res_y;
    assign w_ld_c = w_mul_done ? w_mul_c : w_res_c;
    assign w_ld_v = w_mul_done ? 1'b0    : w_res_v;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_mul) w_state_nxt = S_MUL;
            S_MUL:   if (w_mul_done)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- multiplier registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ma     <= '0;
            r_mb     <= '0;
            r_mop_hi <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_start_mul) begin
            r_ma     <= a;
            r_mb     <= b;
            r_mop_hi <= (op == OP_MULH);
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_cnt    <= r_cnt + SHW'(1);   // wraps to 0 on the final step
        end
    end

    // ---------------- output / flag register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_y         <= w_ld_y;
            r_z         <= (w_ld_y == {W{1'b0}});
            r_n         <= w_ld_y[W-1];
            r_c         <= w_ld_c;
            r_v         <= w_ld_v;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops against an arithmetic reference model.
// Model computes results with plain integer arithmetic and tracks the held carry flag across operations.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same points.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk, rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic [3:0]   op;
    logic         out_valid, out_ready;
    logic [W-1:0] y;
    logic         z, n, c, v, busy;

    int checks = 0;
    int errors = 0;
    logic m_cq = 1'b0;   // model's view of the held carry flag

    alu_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .z(z), .n(n), .c(c), .v(v), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit sovf(input longint x);
        longint maxs, mins;
        maxs = (longint'(1) <<< (W-1)) - 1;
        mins = -(longint'(1) <<< (W-1));
        return (x > maxs) || (x < mins);
    endfunction

    // Returns {y, z, n, c, v}.
    function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [3:0] mop, input logic cq);
        longint ua, ub, sa, sb, lc, r, p, m, maxs, mins;
        logic [W-1:0] ry;
        logic rc, rv;
        int sh;
        m    = longint'(1) <<< W;
        maxs = (longint'(1) <<< (W-1)) - 1;
        mins = -(longint'(1) <<< (W-1));
        ua = longint'(ma); ub = longint'(mb);
        sa = longint'($signed(ma)); sb = longint'($signed(mb));
        lc = cq ? 1 : 0;
        sh = int'(mb) % W;
        ry = '0; rc = 1'b0; rv = 1'b0; r = 0; p = ua * ub;
        case (mop)
            4'h0: begin r = ua + ub;           ry = W'(r); rc = (r >= m); rv = sovf(sa + sb); end
            4'h1: begin r = ua + (m-1-ub) + 1; ry = W'(r); rc = (r >= m); rv = sovf(sa - sb); end
            4'h2: ry = ma & mb;
            4'h3: ry = ma | mb;
            4'h4: ry = ma ^ mb;
            4'h5: ry = ~ma;
            4'h6: ry = W'(ua << sh);
            4'h7: ry = W'(ua >> sh);
            4'h8: ry = W'(sa >>> sh);
            4'h9: ry = (sa < sb) ? W'(1) : W'(0);
            4'hA: ry = ma;
            4'hB: ry = mb;
            4'hC: begin ry = W'(p); rc = ((p >> W) != 0); end
            4'hD: ry = W'(p >> W);
`ifdef ALU_SAT_EN
            4'hE, 4'hF: begin
                r  = (mop == 4'hE) ? sa + sb : sa - sb;
                rv = sovf(r);
                ry = rv ? ((r > maxs) ? W'(maxs) : W'(mins)) : W'(r);
            end
`else
            4'hE: begin r = ua + ub + lc;         ry = W'(r); rc = (r >= m); rv = sovf(sa + sb + lc); end
            4'hF: begin r = ua + (m-1-ub) + lc;   ry = W'(r); rc = (r >= m); rv = sovf(sa - sb - 1 + lc); end
`endif
            default: ;
        endcase
        return {ry, (ry == '0), ry[W-1], rc, rv};
    endfunction

    // Issue one op (consuming any pending result on the same edge), check latency/result,
    // hold the result for 'hold' cycles with out_ready low, then optionally consume it.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [3:0] top,
                         input int hold, input bit consume);
        logic [W+3:0] e;
        int lat;
        bit is_mul;
        is_mul = (top == 4'hC) || (top == 4'hD);
        a = ta; b = tbv; op = top; in_valid = 1'b1; out_ready = out_valid;
        #1;
        lat = 0;
        while (!in_ready && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("issue_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        e = model(ta, tbv, top, m_cq);
        if (is_mul) begin
            chk("mul_busy", busy, 1'b1);
            lat = 0;
            while (!out_valid && lat < 100) begin
                chk("mul_in_ready", in_ready, 1'b0);
                @(posedge clk); #1; lat++;
            end
            chk("mul_latency", lat, W);
            chk("mul_busy_end", busy, 1'b0);
        end else begin
            chk("alu_out_valid", out_valid, 1'b1);
        end
        chk("y", y, e[W+3:4]);
        chk("z", z, e[3]);
        chk("n", n, e[2]);
        chk("c", c, e[1]);
        chk("v", v, e[0]);
        m_cq = e[1];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_y", y, e[W+3:4]);
            chk("hold_c", c, e[1]);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("drain_valid", out_valid, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_y", y, '0);
        chk("rst_flags", {z, n, c, v}, 4'b0);
        chk("rst_busy", busy, 1'b0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Overflow into the sign bit
        do_op(8'h7F, 8'h01, 4'h0, 0, 1);
        // Carry chaining through ADC (result held unconsumed, then chained)
        do_op(8'hFF, 8'h01, 4'h0, 0, 0);
        do_op(8'h00, 8'h00, 4'hE, 0, 1);
        do_op(8'h01, 8'h01, 4'h0, 0, 1);
        do_op(8'h00, 8'h00, 4'hE, 0, 1);
        do_op(8'h00, 8'h01, 4'h1, 0, 1);
        do_op(8'h10, 8'h00, 4'hF, 0, 1);
        // Multiplier halves and zero operands
        do_op(8'h10, 8'h10, 4'hC, 0, 1);
        do_op(8'h10, 8'h10, 4'hD, 0, 1);
        do_op(8'hFF, 8'hFF, 4'hC, 0, 1);
        do_op(8'hFF, 8'hFF, 4'hD, 0, 1);
        do_op(8'h00, 8'h5A, 4'hC, 0, 1);
        do_op(8'hA5, 8'h00, 4'hD, 0, 1);
        // Back-pressure hold
        do_op(8'h05, 8'h07, 4'h1, 3, 1);
        // Shift boundaries: zero amount, arithmetic fill, full range
        do_op(8'hB3, 8'h00, 4'h6, 0, 1);
        do_op(8'hB3, 8'h08, 4'h8, 0, 1);
        do_op(8'h90, 8'h03, 4'h8, 0, 1);
        do_op(8'h90, 8'h07, 4'h7, 0, 1);
        do_op(8'h81, 8'h07, 4'h6, 0, 1);
        do_op(8'h80, 8'h7F, 4'h9, 0, 1);
        do_op(8'h7F, 8'h80, 4'h9, 0, 1);
`ifdef ALU_SAT_EN
        do_op(8'h7F, 8'h01, 4'hE, 0, 1);
        do_op(8'h80, 8'h01, 4'hF, 0, 1);
        do_op(8'h80, 8'hFF, 4'hE, 0, 1);
`endif

        // Back-to-back: result left pending, next op consumes and reloads on the same edge
        do_op(8'h12, 8'h34, 4'h0, 1, 0);
        do_op(8'h0F, 8'hF0, 4'h3, 0, 0);
        do_op(8'h03, 8'h05, 4'hC, 0, 0);
        do_op(8'h40, 8'h40, 4'h0, 0, 1);

        // Reset in the middle of a multiply abandons it
        a = 8'h37; b = 8'h5A; op = 4'hC; in_valid = 1'b1;
        #1;
        chk("rstmul_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmul_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmul_out_valid", out_valid, 1'b0);
        chk("rstmul_busy_clr", busy, 1'b0);
        chk("rstmul_flags", {z, n, c, v}, 4'b0);
        chk("rstmul_y", y, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_cq = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;
        chk("rstmul_no_result", out_valid, 1'b0);
        do_op(8'h02, 8'h03, 4'h0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            do_op(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
        end
        if (out_valid) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
